mod_n_counter: RTL

MOD_N_COUNTER -- requirements
Module: mod_n_counter

---
 rtl/mod_n_counter.sv | 70 +++++++
 1 files changed

// File: rtl/mod_n_counter.sv
// Modulo-MOD up/down counter with parallel load, cascade terminal count,
// registered wrap pulse and a sticky out-of-range-load error flag.
module mod_n_counter #(
   parameter int MOD   = 5,
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             err
);

   generate
      if (MOD < 2 || (2 ** WIDTH) < MOD) begin : g_bad_mod
         $error("mod_n_counter: MOD=%0d does not fit in WIDTH=%0d", MOD, WIDTH);
      end
   endgenerate

   // Arithmetic is carried at WIDTH+1 bits so MOD = 2^WIDTH never overflows.
   localparam logic [WIDTH:0]   LAST_EXT = (WIDTH + 1)'(MOD - 1);
   localparam logic [WIDTH-1:0] LAST_Q   = WIDTH'(MOD - 1);
   localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   din_ext;
   logic             at_top;
   logic             at_bot;
   logic [WIDTH-1:0] q_up;
   logic [WIDTH-1:0] q_dn;
   logic             din_ok;

   assign q_ext   = {1'b0, q};
   assign din_ext = {1'b0, din};
   assign at_top  = (q_ext == LAST_EXT);
   assign at_bot  = (q_ext == '0);
   assign q_up    = at_top ? '0     : WIDTH'(q_ext + ONE_EXT);
   assign q_dn    = at_bot ? LAST_Q : WIDTH'(q_ext - ONE_EXT);
   assign din_ok  = (din_ext <= LAST_EXT);

   // Suppressed during rst/load since neither of those edges is a count.
   assign tc = en & ~rst & ~load & ((up_dn & at_top) | (~up_dn & at_bot));

   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= '0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else if (load) begin
         wrap <= 1'b0;
         if (din_ok) begin
            q <= din;
         end else begin
            q   <= '0;
            err <= 1'b1;
         end
      end else if (en) begin
         q    <= up_dn ? q_up : q_dn;
         wrap <= up_dn ? at_top : at_bot;
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule
